// File: rtl/ext_periph_obi_demux.sv
// OBI 1-to-N demux for the external-peripheral bus: combinational decode and grant, in-order responses.
// Request/response paths are zero-latency; a request to a new target stalls until the previous target drains.
package testharness_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam int unsigned EXT_NPERIPHERALS = 6;
  localparam int unsigned EXT_PERIPHERALS_PORT_SEL_WIDTH = $clog2(EXT_NPERIPHERALS);
  localparam logic [31:0] EXT_PERIPHERAL_START_ADDRESS = 32'h3008_0000;

  // memcopy, AMS, IFFIFO, simple accelerator, im2col SPC, DLC
  localparam addr_map_rule_t [EXT_NPERIPHERALS-1:0] EXT_PERIPHERALS_ADDR_RULES = '{
    '{idx: 32'd5, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h5000, end_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h6000},
    '{idx: 32'd4, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h4000, end_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h5000},
    '{idx: 32'd3, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h3000, end_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h4000},
    '{idx: 32'd2, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h2000, end_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h3000},
    '{idx: 32'd1, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h1000, end_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h1100},
    '{idx: 32'd0, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h0000, end_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h1000}
  };
endpackage

module ext_periph_obi_demux
  import testharness_pkg::*;
#(
  parameter int unsigned                      NPorts    = EXT_NPERIPHERALS,
  parameter addr_map_rule_t [NPorts-1:0]      AddrRules = EXT_PERIPHERALS_ADDR_RULES,
  parameter int unsigned                      MaxTrans  = 2,
  parameter logic [31:0]                      ErrRdata  = 32'hBADCAB1E
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  input  logic [31:0]                  addr_i,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [31:0]                  wdata_i,
  output logic                         gnt_o,
  output logic                         rvalid_o,
  output logic [31:0]                  rdata_o,
  output logic [NPorts-1:0]            per_req_o,
  output logic [NPorts-1:0][31:0]      per_addr_o,
  output logic [NPorts-1:0]            per_we_o,
  output logic [NPorts-1:0][3:0]       per_be_o,
  output logic [NPorts-1:0][31:0]      per_wdata_o,
  input  logic [NPorts-1:0]            per_gnt_i,
  input  logic [NPorts-1:0]            per_rvalid_i,
  input  logic [NPorts-1:0][31:0]      per_rdata_i,
  output logic                         unmapped_o
);

  localparam int unsigned TgtW = $clog2(NPorts) + 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [TgtW-1:0] ErrTgt = TgtW'(NPorts);

  logic [TgtW-1:0] tgt, last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d, err_pend_q, err_pend_d;
  logic            unmapped_q, unmapped_d;
  logic            hit, eligible, to_err, err_slot;
  logic            sel_gnt, sel_rvalid;
  logic [31:0]     sel_rdata;

  // Lowest matching rule wins; anything unmatched goes to the error slot.
  always_comb begin
    tgt = ErrTgt;
    hit = 1'b0;
    for (int k = 0; k < NPorts; k++) begin
      if (!hit && addr_i >= AddrRules[k].start_addr && addr_i < AddrRules[k].end_addr) begin
        hit = 1'b1;
        tgt = AddrRules[k].idx[TgtW-1:0];
      end
    end
  end

  always_comb begin
    sel_gnt    = 1'b0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int p = 0; p < NPorts; p++) begin
      if (tgt == TgtW'(p)) sel_gnt = per_gnt_i[p];
      if (last_q == TgtW'(p)) begin
        sel_rvalid = per_rvalid_i[p];
        sel_rdata  = per_rdata_i[p];
      end
    end
  end

  assign to_err   = (tgt == ErrTgt);
  assign err_slot = (last_q == ErrTgt);
  assign eligible = (cnt_q < CntW'(MaxTrans)) && ((cnt_q == '0) || (tgt == last_q));

  always_comb begin
    per_req_o = '0;
    for (int p = 0; p < NPorts; p++) begin
      if (req_i && eligible && tgt == TgtW'(p)) per_req_o[p] = 1'b1;
    end
  end

  assign gnt_o    = rst_ni & req_i & eligible & (to_err | sel_gnt);
  assign rvalid_o = rst_ni & (cnt_q != '0) & (err_slot ? (err_pend_q != '0) : sel_rvalid);
  assign rdata_o  = err_slot ? ErrRdata : sel_rdata;

  assign per_addr_o  = {NPorts{addr_i}};
  assign per_we_o    = {NPorts{we_i}};
  assign per_be_o    = {NPorts{be_i}};
  assign per_wdata_o = {NPorts{wdata_i}};

  always_comb begin
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    last_d     = gnt_o ? tgt : last_q;
    unmapped_d = unmapped_q | (gnt_o & to_err);
    if (gnt_o && !rvalid_o)      cnt_d = cnt_q + CntW'(1);
    else if (!gnt_o && rvalid_o) cnt_d = cnt_q - CntW'(1);
    // The error responder drains one pending access per cycle, starting the cycle after its grant.
    if ((gnt_o && to_err) && !(rvalid_o && err_slot))      err_pend_d = err_pend_q + CntW'(1);
    else if (!(gnt_o && to_err) && (rvalid_o && err_slot)) err_pend_d = err_pend_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      last_q     <= '0;
      err_pend_q <= '0;
      unmapped_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      err_pend_q <= err_pend_d;
      unmapped_q <= unmapped_d;
    end
  end

  assign unmapped_o = unmapped_q;

endmodule
